// File: rtl/reg_pkg.sv
// Shared register-file definitions: widths, reset value, address/data types
// and small decode helpers. Used by reg_file, its scoreboard, the downstream
// operand-select mux and the decoder.
// Optional build macro REG_FILE_R0_ZERO_EN makes r0 a constant-zero register.
package reg_pkg;

  localparam int REG_W      = 16;
  localparam int REG_CNT    = 8;
  localparam int REG_ADDR_W = 3;

  localparam logic [REG_W-1:0] REG_RST_VAL = 16'h0000;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_W-1:0]      reg_data_t;
  typedef logic [REG_CNT-1:0]    reg_vec_t;

  // One write request as seen by the storage array
  typedef struct packed {
    logic      en;
    reg_addr_t addr;
    reg_data_t data;
  } reg_wr_t;

  // Expand a register address into a one-hot select vector
  function automatic reg_vec_t addr_onehot(input reg_addr_t addr);
    reg_vec_t vec;
    vec = '0;
    vec[addr] = 1'b1;
    return vec;
  endfunction

  // True when a write or lock to this address has any architectural effect
  function automatic logic addr_writable(input reg_addr_t addr);
`ifdef REG_FILE_R0_ZERO_EN
    return (addr != '0);
`else
    return (addr == addr) ? 1'b1 : 1'b0;
`endif
  endfunction

  // Select vector for an enabled request, masked by writability
  function automatic reg_vec_t req_select(input logic en, input reg_addr_t addr);
    if (en && addr_writable(addr)) begin
      return addr_onehot(addr);
    end
    return '0;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-load scoreboard for the register file: one busy flag per register,
// set when a load is issued and cleared when its write-back lands, plus the
// sticky write-after-write hazard flag raised when the ALU port writes a
// register that still has a load in flight.
// With REG_FILE_R0_ZERO_EN defined, address 0 can never become busy and never
// raises the hazard flag.
module reg_scoreboard
  import reg_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      lock_set,
  input  reg_addr_t lock_addr,
  input  logic      clr_en,
  input  reg_addr_t clr_addr,
  input  logic      wa_en,
  input  reg_addr_t wa_addr,
  output reg_vec_t  busy,
  output logic      waw_err
);

  reg_vec_t set_vec;
  reg_vec_t clr_vec;
  reg_vec_t busy_next;
  logic     waw_hit;

  // Next busy vector: clear the landing load first, then apply a new lock so a
  // back-to-back load to the same register keeps it busy
  always_comb begin
    set_vec   = req_select(lock_set, lock_addr);
    clr_vec   = clr_en ? addr_onehot(clr_addr) : '0;
    busy_next = (busy & ~clr_vec) | set_vec;
    waw_hit   = wa_en && busy[wa_addr] && addr_writable(wa_addr);
  end

  // Busy flags and sticky hazard flag; only reset clears the hazard
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= '0;
      waw_err <= 1'b0;
    end else begin
      busy <= busy_next;
      if (waw_hit) begin
        waw_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_file.sv
// Architectural register file r0..r7 with two write-back sources:
//   port A - ALU result, unconditional when wa_en is high
//   port B - load result, valid/ready handshake, yields to port A when both
//            target the same register in the same cycle
// All eight registers are presented in parallel for the operand-select mux.
// There is no write-to-read bypass; forwarding belongs to the controller.
// Optional build macro REG_FILE_R0_ZERO_EN: r0 reads as constant zero, writes
// to address 0 are dropped (a port B transfer still completes) and address 0
// never becomes busy.
module reg_file
  import reg_pkg::*;
#(
  parameter int               WIDTH   = REG_W,
  parameter int               NREG    = REG_CNT,
  parameter logic [WIDTH-1:0] RST_VAL = REG_RST_VAL
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wa_en,
  input  logic [2:0]       wa_addr,
  input  logic [WIDTH-1:0] wa_data,
  input  logic             wb_valid,
  output logic             wb_ready,
  input  logic [2:0]       wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  input  logic             lock_set,
  input  logic [2:0]       lock_addr,
  output logic [NREG-1:0]  busy,
  output logic             waw_err,
  output logic [WIDTH-1:0] r0,
  output logic [WIDTH-1:0] r1,
  output logic [WIDTH-1:0] r2,
  output logic [WIDTH-1:0] r3,
  output logic [WIDTH-1:0] r4,
  output logic [WIDTH-1:0] r5,
  output logic [WIDTH-1:0] r6,
  output logic [WIDTH-1:0] r7
);

  logic [WIDTH-1:0] regs [NREG];
  logic [NREG-1:0]  wa_sel;
  logic [NREG-1:0]  wb_sel;
  logic             wb_fire;
  reg_vec_t         sb_busy;

  // Port B stalls only when port A targets the same register this cycle
  assign wb_ready = !(wa_en && (wa_addr == wb_addr));
  assign wb_fire  = wb_valid && wb_ready;

  // Per-register write selects; port A and port B never select the same entry
  always_comb begin
    wa_sel = req_select(wa_en, wa_addr);
    wb_sel = req_select(wb_fire, wb_addr);
  end

  // Storage array; r0 resets to zero and is never written when hardwired
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= RST_VAL;
      end
`ifdef REG_FILE_R0_ZERO_EN
      regs[0] <= '0;
`endif
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (wa_sel[i]) begin
          regs[i] <= wa_data;
        end else if (wb_sel[i]) begin
          regs[i] <= wb_data;
        end
      end
    end
  end

  reg_scoreboard u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .lock_set  (lock_set),
    .lock_addr (lock_addr),
    .clr_en    (wb_fire),
    .clr_addr  (wb_addr),
    .wa_en     (wa_en),
    .wa_addr   (wa_addr),
    .busy      (sb_busy),
    .waw_err   (waw_err)
  );

  assign busy = sb_busy;

  assign r0 = regs[0];
  assign r1 = regs[1];
  assign r2 = regs[2];
  assign r3 = regs[3];
  assign r4 = regs[4];
  assign r5 = regs[5];
  assign r6 = regs[6];
  assign r7 = regs[7];

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard testbench for reg_file. Each directed vector pushes its expected
// post-edge state; a monitor pops and compares on the following falling edge.
// Expectations for address 0 follow REG_FILE_R0_ZERO_EN when it is defined.
module tb_reg_file;
  import reg_pkg::*;

`ifdef REG_FILE_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif

  typedef struct {
    string           name;
    logic [127:0]    regs;
    logic [7:0]      busy;
    logic            waw;
    logic            ready;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        wa_en;
  logic [2:0]  wa_addr;
  logic [15:0] wa_data;
  logic        wb_valid;
  logic        wb_ready;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        lock_set;
  logic [2:0]  lock_addr;
  logic [7:0]  busy;
  logic        waw_err;
  logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;

  logic [15:0] exp_r [8];
  exp_t        exp_q [$];
  int          checks;
  int          errors;

  reg_file dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wa_en     (wa_en),
    .wa_addr   (wa_addr),
    .wa_data   (wa_data),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .lock_set  (lock_set),
    .lock_addr (lock_addr),
    .busy      (busy),
    .waw_err   (waw_err),
    .r0        (r0),
    .r1        (r1),
    .r2        (r2),
    .r3        (r3),
    .r4        (r4),
    .r5        (r5),
    .r6        (r6),
    .r7        (r7)
  );

  // Free-running clock, 10 time units per cycle
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [127:0] pack_exp();
    logic [127:0] v;
    for (int i = 0; i < 8; i++) begin
      v[i*16 +: 16] = exp_r[i];
    end
    return v;
  endfunction

  task automatic pushExpect(input string name, input logic [7:0] e_busy,
                            input logic e_waw, input logic e_ready);
    exp_t e;
    e.name  = name;
    e.regs  = pack_exp();
    e.busy  = e_busy;
    e.waw   = e_waw;
    e.ready = e_ready;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [127:0] act;
    act = {r7, r6, r5, r4, r3, r2, r1, r0};
    checks++;
    if (act !== e.regs) begin
      errors++;
      $display("[TB] FAIL %s regs: got %h expected %h", e.name, act, e.regs);
    end
    checks++;
    if (busy !== e.busy) begin
      errors++;
      $display("[TB] FAIL %s busy: got %h expected %h", e.name, busy, e.busy);
    end
    checks++;
    if (waw_err !== e.waw) begin
      errors++;
      $display("[TB] FAIL %s waw_err: got %b expected %b", e.name, waw_err, e.waw);
    end
    checks++;
    if (wb_ready !== e.ready) begin
      errors++;
      $display("[TB] FAIL %s wb_ready: got %b expected %b", e.name, wb_ready, e.ready);
    end
  endtask

  // Monitor: compare the oldest expectation once its edge has passed
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      checkOutput(exp_q.pop_front());
    end
  end

  task automatic applyStimulus(input string name,
                               input logic a_en, input logic [2:0] a_addr, input logic [15:0] a_data,
                               input logic b_val, input logic [2:0] b_addr, input logic [15:0] b_data,
                               input logic l_set, input logic [2:0] l_addr,
                               input logic [7:0] e_busy, input logic e_waw, input logic e_ready);
    @(negedge clk);
    #1;
    wa_en     = a_en;
    wa_addr   = a_addr;
    wa_data   = a_data;
    wb_valid  = b_val;
    wb_addr   = b_addr;
    wb_data   = b_data;
    lock_set  = l_set;
    lock_addr = l_addr;
    pushExpect(name, e_busy, e_waw, e_ready);
  endtask

  task automatic resetDut(input string name);
    @(negedge clk);
    #1;
    wa_en    = 1'b0;
    wb_valid = 1'b0;
    lock_set = 1'b0;
    wa_addr  = 3'd0;
    wb_addr  = 3'd1;
    rst_n    = 1'b0;
    for (int i = 0; i < 8; i++) exp_r[i] = 16'h0000;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    pushExpect(name, 8'h00, 1'b0, 1'b1);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    wa_en     = 1'b0;
    wa_addr   = 3'd0;
    wa_data   = 16'h0;
    wb_valid  = 1'b0;
    wb_addr   = 3'd1;
    wb_data   = 16'h0;
    lock_set  = 1'b0;
    lock_addr = 3'd0;
    for (int i = 0; i < 8; i++) exp_r[i] = 16'h0000;
    repeat (2) @(posedge clk);
    resetDut("reset_defaults");

    // Sequential port A writes
    exp_r[3] = 16'hBEEF;
    applyStimulus("wa_r3", 1, 3'd3, 16'hBEEF, 0, 3'd1, 16'h0, 0, 3'd0, 8'h00, 0, 1);
    exp_r[5] = 16'h1234;
    applyStimulus("wa_r5", 1, 3'd5, 16'h1234, 0, 3'd1, 16'h0, 0, 3'd0, 8'h00, 0, 1);

    // Same-address conflict: port A wins, port B retries next cycle
    exp_r[2] = 16'h00AA;
    applyStimulus("conflict_a_wins", 1, 3'd2, 16'h00AA, 1, 3'd2, 16'h0055, 0, 3'd0, 8'h00, 0, 0);
    exp_r[2] = 16'h0055;
    applyStimulus("conflict_b_retry", 0, 3'd2, 16'h0000, 1, 3'd2, 16'h0055, 0, 3'd0, 8'h00, 0, 1);

    // Scoreboard set / clear / set-wins
    applyStimulus("lock6", 0, 3'd0, 16'h0, 0, 3'd1, 16'h0, 1, 3'd6, 8'h40, 0, 1);
    exp_r[6] = 16'h7777;
    applyStimulus("load6_clears", 0, 3'd0, 16'h0, 1, 3'd6, 16'h7777, 0, 3'd0, 8'h00, 0, 1);
    applyStimulus("relock6", 0, 3'd0, 16'h0, 0, 3'd1, 16'h0, 1, 3'd6, 8'h40, 0, 1);
    exp_r[6] = 16'h1111;
    applyStimulus("set_wins6", 0, 3'd0, 16'h0, 1, 3'd6, 16'h1111, 1, 3'd6, 8'h40, 0, 1);
    exp_r[6] = 16'h2222;
    applyStimulus("load6_final", 0, 3'd0, 16'h0, 1, 3'd6, 16'h2222, 0, 3'd0, 8'h00, 0, 1);

    // Both ports to different registers; port B to a non-busy register
    exp_r[1] = 16'h0A0A;
    exp_r[7] = 16'h0B0B;
    applyStimulus("dual_write", 1, 3'd1, 16'h0A0A, 1, 3'd7, 16'h0B0B, 0, 3'd0, 8'h00, 0, 1);

    // Address 0 behaviour (ordinary register unless hardwired to zero)
    applyStimulus("lock0", 0, 3'd1, 16'h0, 0, 3'd2, 16'h0, 1, 3'd0, R0Z ? 8'h00 : 8'h01, 0, 1);
    exp_r[0] = R0Z ? 16'h0000 : 16'hFFFF;
    applyStimulus("wa_r0", 1, 3'd0, 16'hFFFF, 0, 3'd2, 16'h0, 0, 3'd0, R0Z ? 8'h00 : 8'h01, !R0Z, 1);
    exp_r[0] = R0Z ? 16'h0000 : 16'h1357;
    applyStimulus("load_r0", 0, 3'd1, 16'h0, 1, 3'd0, 16'h1357, 0, 3'd0, 8'h00, !R0Z, 1);

    // Reset mid-operation discards the pending lock and the hazard flag
    applyStimulus("lock5", 0, 3'd1, 16'h0, 0, 3'd2, 16'h0, 1, 3'd5, 8'h20, !R0Z, 1);
    resetDut("reset_mid_op");

    // WAW hazard: write lands, busy kept, sticky flag until reset
    applyStimulus("lock4", 0, 3'd1, 16'h0, 0, 3'd2, 16'h0, 1, 3'd4, 8'h10, 0, 1);
    exp_r[4] = 16'h0001;
    applyStimulus("waw_r4", 1, 3'd4, 16'h0001, 0, 3'd2, 16'h0, 0, 3'd0, 8'h10, 1, 1);
    applyStimulus("waw_sticky", 0, 3'd1, 16'h0, 0, 3'd2, 16'h0, 0, 3'd0, 8'h10, 1, 1);
    applyStimulus("relock4_busy", 0, 3'd1, 16'h0, 0, 3'd2, 16'h0, 1, 3'd4, 8'h10, 1, 1);
    resetDut("reset_clears_waw");

    // Drain the scoreboard, bounded by a cycle budget
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
